coin_scheduler: RTL
===================

// Module: coin_scheduler
// PURPOSE
//  Owns all coin pop-up animations in the level. Accepts block-hit spawn requests and allocates one of
//  NUM_SLOTS animation slots. Sequences each slot: rise, fall, then retire. Arbitrates retiring slots onto
//  a single score port. Sits between block-collision logic and the sprite renderer/HUD, in clk_pixel domain.
// PARAMETERS
//  NUM_SLOTS      4   concurrent coin animations (power of 2, 2..8)
//  RISE_PX        32  pixels a coin rises above its spawn y
//  FRAMES_PER_PX  2   new_frame pulses per 1-pixel y step (>=1)
//  ANIM_DIV       4   new_frame pulses per sprite-frame index advance (>=1)
// PORTS
//  clk_pixel    in   1      pixel clock; all state on rising edge
//  sys_rst      in   1      asynchronous, active-high reset
//  new_frame    in   1      one-cycle pulse per video frame
//  hit_valid    in   1      spawn request from collision logic
//  hit_ready    out  1      high when at least one slot is IDLE
//  hit_x        in   13     world x of spawning block (captured on accept)
//  hit_y        in   10     screen y of spawning block (captured on accept)
//  rd_idx       in   $clog2(NUM_SLOTS)  renderer slot query index
//  rd_active    out  1      queried slot is in RISE or FALL (registered)
//  rd_x         out  13     queried slot x (registered)
//  rd_y         out  10     queried slot current y (registered)
//  rd_frame     out  2      queried slot sprite index (registered)
//  score_pulse  out  1      one-cycle pulse per retired coin
//  coin_count   out  7      coins collected, 0..99
//  life_up      out  1      one-cycle pulse when coin_count wraps 99->0
// BEHAVIOUR
//  Reset (async, any time, incl. mid-animation): all slots IDLE; all counters 0. All outputs 0 except
//   hit_ready=1. No pending retirement survives reset.
//  Handshake: accept = hit_valid & hit_ready. Lowest-index IDLE slot is allocated that cycle. It enters RISE
//   next edge with x=hit_x, y=y_home=hit_y, y_top=(hit_y>=RISE_PX)?hit_y-RISE_PX:0, sub=0, frame=0.
//   hit_valid with hit_ready=0 is ignored; no queueing.
//  Slot FSM (per slot): IDLE -> RISE -> FALL -> DONE -> IDLE.
//   RISE: on new_frame, if sub==FRAMES_PER_PX-1 then sub<=0, y<=y-1, else sub<=sub+1.
//         Transitions to FALL on the step where y reaches y_top (y==y_top at entry: FALL next new_frame).
//   FALL: same stepping with y<=y+1; -> DONE when y reaches y_home.
//   DONE: holds until granted by retire arbiter, then -> IDLE next edge.
//   Slot counts as free only in IDLE; a slot granted this cycle is not allocatable until next cycle.
//  Anim: in RISE/FALL, frame advances mod 4 every ANIM_DIV new_frame pulses. Frame freezes in DONE.
//  y arithmetic: 10-bit unsigned; clamping at y_top guarantees no underflow.
//  Retire arbiter: round-robin over DONE slots, one grant per cycle; pointer moves past the granted slot.
//   Grant -> score_pulse=1 next cycle; coin_count+1 (99 -> 0 with life_up=1 same cycle as the wrap).
//  Query port: rd_* = state of slot rd_idx, 1-cycle latency. IDLE/DONE slots read rd_active=0.
//  Simultaneous accept and grant in same cycle are independent; both take effect.
// STRUCTURE
//  coin_pkg: slot_state_t enum {IDLE,RISE,FALL,DONE}, coin_slot_t struct {x,y,y_home,y_top,sub,frame},
//   COIN_MAX=99 constant.
//  Sub-module coin_slot: one slot FSM + y/sub/frame counters; NUM_SLOTS instances via generate.
//  Top: priority allocator, round-robin retire arbiter, coin counter, registered query mux.
// TESTING
//  1 Reset, spawn hit_x=384 hit_y=160, FRAMES_PER_PX=2 -> slot0 rd_y reaches 128 after 64 frames,
//    returns to 160 after 128 frames total; exactly one score_pulse; coin_count=1.
//  2 Spawn 4 coins back-to-back -> slots 0..3 allocated in order; hit_ready=0; 5th hit_valid ignored;
//    hit_ready=1 the cycle after the first grant.
//  3 4 slots spawned the same cycle-sequence reach DONE together -> 4 score_pulses on 4 consecutive
//    cycles, round-robin order; coin_count +4.
//  4 hit_y=20, RISE_PX=32 -> y clamps at 0, no wrap to 1023; then falls back to 20.
//  5 coin_count preloaded to 99 via 99 retirements, retire one more -> coin_count=0, life_up pulses once.
//  6 Assert sys_rst mid-RISE with a slot in DONE -> all outputs 0 immediately, hit_ready=1, no score_pulse.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin pop-up scheduler.
package coin_pkg;

  localparam int unsigned COIN_MAX = 99;
  localparam int unsigned SubW     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRise,
    StFall,
    StDone
  } slot_state_t;

  typedef struct packed {
    logic [12:0]     x;
    logic [9:0]      y;
    logic [9:0]      y_home;
    logic [9:0]      y_top;
    logic [SubW-1:0] sub;
    logic [1:0]      frame;
  } coin_slot_t;

endpackage

// File: rtl/coin_slot.sv
// One coin animation slot: rises to y_top, falls back to y_home, then waits in
// DONE until the retire arbiter grants it.
module coin_slot
  import coin_pkg::*;
#(
  parameter int unsigned RISE_PX       = 32,
  parameter int unsigned FRAMES_PER_PX = 2,
  parameter int unsigned ANIM_DIV      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_frame_i,
  input  logic        spawn_i,
  input  logic [12:0] spawn_x_i,
  input  logic [9:0]  spawn_y_i,
  input  logic        grant_i,
  output slot_state_t state_o,
  output coin_slot_t  slot_o
);

  localparam logic [SubW-1:0] SubLast  = SubW'(FRAMES_PER_PX - 1);
  localparam logic [7:0]      AnimLast = 8'(ANIM_DIV - 1);
  localparam logic [9:0]      RisePx   = 10'(RISE_PX);

  slot_state_t state_q, state_d;
  coin_slot_t  slot_q, slot_d;
  logic [7:0]  anim_q, anim_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    anim_d  = anim_q;
    case (state_q)
      StIdle: begin
        if (spawn_i) begin
          state_d       = StRise;
          slot_d.x      = spawn_x_i;
          slot_d.y      = spawn_y_i;
          slot_d.y_home = spawn_y_i;
          slot_d.y_top  = (spawn_y_i >= RisePx) ? spawn_y_i - RisePx : '0;
          slot_d.sub    = '0;
          slot_d.frame  = '0;
          anim_d        = '0;
        end
      end
      StRise: begin
        if (new_frame_i) begin
          // Already at the apex on entry (clamped spawn near the top): turn around.
          if (slot_q.y == slot_q.y_top) begin
            state_d    = StFall;
            slot_d.sub = '0;
          end else if (slot_q.sub == SubLast) begin
            slot_d.sub = '0;
            slot_d.y   = slot_q.y - 10'd1;
            if (slot_d.y == slot_q.y_top) state_d = StFall;
          end else begin
            slot_d.sub = slot_q.sub + 1'b1;
          end
        end
      end
      StFall: begin
        if (new_frame_i) begin
          if (slot_q.y == slot_q.y_home) begin
            state_d    = StDone;
            slot_d.sub = '0;
          end else if (slot_q.sub == SubLast) begin
            slot_d.sub = '0;
            slot_d.y   = slot_q.y + 10'd1;
            if (slot_d.y == slot_q.y_home) state_d = StDone;
          end else begin
            slot_d.sub = slot_q.sub + 1'b1;
          end
        end
      end
      StDone: begin
        if (grant_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (new_frame_i && (state_q == StRise || state_q == StFall)) begin
      if (anim_q == AnimLast) begin
        anim_d       = '0;
        slot_d.frame = slot_q.frame + 2'd1;
      end else begin
        anim_d = anim_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      slot_q  <= '0;
      anim_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      anim_q  <= anim_d;
    end
  end

  assign state_o = state_q;
  assign slot_o  = slot_q;

endmodule

// File: rtl/coin_scheduler.sv
// Coin animation scheduler: allocates slots to block hits, retires finished
// coins round-robin onto the score port, and serves renderer slot queries.
module coin_scheduler
  import coin_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS     = 4,
  parameter  int unsigned RISE_PX       = 32,
  parameter  int unsigned FRAMES_PER_PX = 2,
  parameter  int unsigned ANIM_DIV      = 4,
  localparam int unsigned IdxW          = $clog2(NUM_SLOTS)
) (
  input  logic            clk_pixel,
  input  logic            sys_rst,
  input  logic            new_frame,
  input  logic            hit_valid,
  output logic            hit_ready,
  input  logic [12:0]     hit_x,
  input  logic [9:0]      hit_y,
  input  logic [IdxW-1:0] rd_idx,
  output logic            rd_active,
  output logic [12:0]     rd_x,
  output logic [9:0]      rd_y,
  output logic [1:0]      rd_frame,
  output logic            score_pulse,
  output logic [6:0]      coin_count,
  output logic            life_up
);

  slot_state_t          state [NUM_SLOTS];
  coin_slot_t           slot  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] idle, done, spawn, grant;
  logic                 found, grant_vld;
  logic [IdxW-1:0]      grant_idx, idx, ptr_q, ptr_d;
  logic [6:0]           count_q, count_d;
  logic                 score_q, life_q, life_d;
  logic                 rd_active_q, rd_active_d;
  logic [12:0]          rd_x_q;
  logic [9:0]           rd_y_q;
  logic [1:0]           rd_frame_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign idle[i] = (state[i] == StIdle);
    assign done[i] = (state[i] == StDone);

    coin_slot #(
      .RISE_PX      (RISE_PX),
      .FRAMES_PER_PX(FRAMES_PER_PX),
      .ANIM_DIV     (ANIM_DIV)
    ) u_slot (
      .clk_i      (clk_pixel),
      .rst_i      (sys_rst),
      .new_frame_i(new_frame),
      .spawn_i    (spawn[i]),
      .spawn_x_i  (hit_x),
      .spawn_y_i  (hit_y),
      .grant_i    (grant[i]),
      .state_o    (state[i]),
      .slot_o     (slot[i])
    );
  end

  assign hit_ready = |idle;

  // Lowest-index idle slot takes the hit.
  always_comb begin
    spawn = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (idle[i] && !found) begin
        spawn[i] = hit_valid;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_SLOTS; off++) begin
      idx = ptr_q + IdxW'(off);
      if (!grant_vld && done[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    grant            = '0;
    grant[grant_idx] = grant_vld;
    ptr_d            = grant_vld ? grant_idx + 1'b1 : ptr_q;
  end

  always_comb begin
    count_d = count_q;
    life_d  = 1'b0;
    if (grant_vld) begin
      if (count_q == 7'(COIN_MAX)) begin
        count_d = '0;
        life_d  = 1'b1;
      end else begin
        count_d = count_q + 7'd1;
      end
    end
    rd_active_d = (state[rd_idx] == StRise) || (state[rd_idx] == StFall);
  end

  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      score_q     <= 1'b0;
      life_q      <= 1'b0;
      rd_active_q <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_frame_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      score_q     <= grant_vld;
      life_q      <= life_d;
      rd_active_q <= rd_active_d;
      rd_x_q      <= slot[rd_idx].x;
      rd_y_q      <= slot[rd_idx].y;
      rd_frame_q  <= slot[rd_idx].frame;
    end
  end

  assign score_pulse = score_q;
  assign coin_count  = count_q;
  assign life_up     = life_q;
  assign rd_active   = rd_active_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign rd_frame    = rd_frame_q;

endmodule
